// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the three-way memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 8;
  localparam int STARVE_MAX_DEF = 8;

  // Which requester the RAM read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BLT  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/grant/return bundle for the upload, blitter and CPU ports plus the
// single-port RAM command, as seen by the arbiter (slave) and by whatever
// drives the requesters and the RAM (master).
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);

  logic              up_session;
  logic              up_req;
  logic [ADDR_W-1:0] up_addr;
  logic [DATA_W-1:0] up_wdata;
  logic              up_gnt;

  logic              blt_req;
  logic [ADDR_W-1:0] blt_addr;
  logic              blt_gnt;
  logic              blt_rvalid;
  logic [DATA_W-1:0] blt_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              busy;

  modport slave (
    input  up_session, up_req, up_addr, up_wdata,
    input  blt_req, blt_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ram_rdata,
    output up_gnt, blt_gnt, blt_rvalid, blt_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output busy
  );

  modport master (
    output up_session, up_req, up_addr, up_wdata,
    output blt_req, blt_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ram_rdata,
    input  up_gnt, blt_gnt, blt_rvalid, blt_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  busy
  );

endinterface

// File: rtl/arb_pick.sv
// Purely combinational grant selector: upload first, then blitter, then CPU,
// with a starved CPU jumping ahead of the blitter but never ahead of upload.
module arb_pick (
  input  logic en,
  input  logic up_session,
  input  logic up_req,
  input  logic blt_req,
  input  logic cpu_req,
  input  logic starve_sat,
  output logic up_gnt,
  output logic blt_gnt,
  output logic cpu_gnt
);

  // One-hot (or zero) grant from current requests and starvation state.
  always_comb begin
    up_gnt  = 1'b0;
    blt_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (en) begin
      if (up_req) begin
        up_gnt = 1'b1;
      end else if (!up_session) begin
        if (cpu_req && starve_sat) begin
          cpu_gnt = 1'b1;
        end else if (blt_req) begin
          blt_gnt = 1'b1;
        end else if (cpu_req) begin
          cpu_gnt = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for upload (write), blitter (read) and CPU
// (read/write). Grants and the RAM command are combinational; the starvation
// counter, read-return owner tag and busy flag are registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          res,
  mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]     starve_q, starve_d;
  owner_e            owner_q, owner_d;
  logic              busy_q, busy_d;

  logic              up_gnt, blt_gnt, cpu_gnt;
  logic              starve_sat;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  assign starve_sat = (starve_q == SW'(STARVE_MAX));

  // Grants are held off for as long as reset is asserted and are live again
  // as soon as it releases.
  arb_pick u_pick (
    .en         (res),
    .up_session (bus.up_session),
    .up_req     (bus.up_req),
    .blt_req    (bus.blt_req),
    .cpu_req    (bus.cpu_req),
    .starve_sat (starve_sat),
    .up_gnt     (up_gnt),
    .blt_gnt    (blt_gnt),
    .cpu_gnt    (cpu_gnt)
  );

  // Route the granted requester onto the RAM command port.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    if (up_gnt) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      addr_sel  = bus.up_addr;
      wdata_sel = bus.up_wdata;
    end else if (blt_gnt) begin
      ram_en    = 1'b1;
      addr_sel  = bus.blt_addr;
    end else if (cpu_gnt) begin
      ram_en    = 1'b1;
      ram_we    = bus.cpu_we;
      addr_sel  = bus.cpu_addr;
      wdata_sel = bus.cpu_wdata;
    end
  end

  // Next starvation count, read-return owner and busy flag.
  always_comb begin
    starve_d = starve_q;
    if (cpu_gnt) begin
      starve_d = '0;
    end else if (bus.cpu_req && !starve_sat) begin
      starve_d = starve_q + SW'(1);
    end

    owner_d = OWN_NONE;
    if (blt_gnt) begin
      owner_d = OWN_BLT;
    end else if (cpu_gnt && !bus.cpu_we) begin
      owner_d = OWN_CPU;
    end

    busy_d = (bus.up_req  && !up_gnt)  ||
             (bus.blt_req && !blt_gnt) ||
             (bus.cpu_req && !cpu_gnt) ||
             (owner_d != OWN_NONE);
  end

  // State registers; reset drops any read return still in flight.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      starve_q <= '0;
      owner_q  <= OWN_NONE;
      busy_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.up_gnt     = up_gnt;
  assign bus.blt_gnt    = blt_gnt;
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.ram_en     = ram_en;
  assign bus.ram_we     = ram_we;
  assign bus.ram_addr   = addr_sel;
  assign bus.ram_wdata  = wdata_sel;
  assign bus.busy       = busy_q;

  assign bus.blt_rvalid = (owner_q == OWN_BLT);
  assign bus.cpu_rvalid = (owner_q == OWN_CPU);
  assign bus.blt_rdata  = (owner_q == OWN_BLT) ? bus.ram_rdata : '0;
  assign bus.cpu_rdata  = (owner_q == OWN_CPU) ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM.
module tb_mem_arbiter;

  logic clk;
  logic res;
  int   checks;
  int   failures;
  logic [7:0] mem [4096];
  logic [7:0] ram_rdata_r;

  mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_MAX(8)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: synchronous read, one-cycle latency; preloaded while reset is low.
  always @(posedge clk) begin
    if (!res) begin
      mem[12'h200] <= 8'hA2;
      mem[12'h010] <= 8'h3C;
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_rdata_r       <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = ram_rdata_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic u, input logic b, input logic c);
    chk({tag, ".up_gnt"},  {31'd0, bus.up_gnt},  {31'd0, u});
    chk({tag, ".blt_gnt"}, {31'd0, bus.blt_gnt}, {31'd0, b});
    chk({tag, ".cpu_gnt"}, {31'd0, bus.cpu_gnt}, {31'd0, c});
  endtask

  task automatic chk_idle(input string tag);
    chk_gnt(tag, 1'b0, 1'b0, 1'b0);
    chk({tag, ".ram_en"},     {31'd0, bus.ram_en},     32'd0);
    chk({tag, ".ram_we"},     {31'd0, bus.ram_we},     32'd0);
    chk({tag, ".busy"},       {31'd0, bus.busy},       32'd0);
    chk({tag, ".blt_rvalid"}, {31'd0, bus.blt_rvalid}, 32'd0);
    chk({tag, ".cpu_rvalid"}, {31'd0, bus.cpu_rvalid}, 32'd0);
    chk({tag, ".blt_rdata"},  {24'd0, bus.blt_rdata},  32'd0);
    chk({tag, ".cpu_rdata"},  {24'd0, bus.cpu_rdata},  32'd0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    res = 1'b0;
    bus.up_session = 1'b0;
    bus.up_req = 1'b1;  bus.up_addr = 12'h000;  bus.up_wdata = 8'h00;
    bus.blt_req = 1'b1; bus.blt_addr = 12'h000;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h000; bus.cpu_wdata = 8'h00;

    // Reset: every request high, yet nothing may be granted.
    repeat (2) @(posedge clk);
    smp();
    chk_idle("rst");
    bus.up_req = 1'b0; bus.blt_req = 1'b0; bus.cpu_req = 1'b0;
    res = 1'b1;

    // CPU read of 0x200 alone.
    nxt();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200;
    smp();
    chk_gnt("cpurd", 1'b0, 1'b0, 1'b1);
    chk("cpurd.ram_en",   {31'd0, bus.ram_en}, 32'd1);
    chk("cpurd.ram_we",   {31'd0, bus.ram_we}, 32'd0);
    chk("cpurd.ram_addr", {20'd0, bus.ram_addr}, 32'h200);
    nxt();
    bus.cpu_req = 1'b0;
    smp();
    chk("cpurd.rvalid",     {31'd0, bus.cpu_rvalid}, 32'd1);
    chk("cpurd.rdata",      {24'd0, bus.cpu_rdata},  32'hA2);
    chk("cpurd.blt_rvalid", {31'd0, bus.blt_rvalid}, 32'd0);

    // Upload session: four writes, CPU and blitter held off.
    nxt();
    bus.up_session = 1'b1;
    bus.up_req = 1'b1; bus.up_addr = 12'h300; bus.up_wdata = 8'h55;
    bus.blt_req = 1'b1; bus.blt_addr = 12'h010;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h300;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk_gnt("upsess", 1'b1, 1'b0, 1'b0);
      chk("upsess.ram_we",   {31'd0, bus.ram_we},   32'd1);
      chk("upsess.ram_addr", {20'd0, bus.ram_addr}, 32'h300);
      if (i < 3) nxt();
    end
    nxt();
    bus.up_session = 1'b0; bus.up_req = 1'b0; bus.blt_req = 1'b0;
    smp();
    chk_gnt("upsess.cpu", 1'b0, 1'b0, 1'b1);
    nxt();
    bus.cpu_req = 1'b0;
    smp();
    chk("upsess.rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
    chk("upsess.rdata",  {24'd0, bus.cpu_rdata},  32'h55);

    // CPU write then read-after-write; session rises with the return pending.
    nxt();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h050; bus.cpu_wdata = 8'h11;
    smp();
    chk_gnt("raw.wr", 1'b0, 1'b0, 1'b1);
    chk("raw.wr.ram_we",    {31'd0, bus.ram_we},    32'd1);
    chk("raw.wr.ram_wdata", {24'd0, bus.ram_wdata}, 32'h11);
    nxt();
    bus.cpu_we = 1'b0;
    smp();
    chk_gnt("raw.rd", 1'b0, 1'b0, 1'b1);
    chk("raw.rd.ram_we", {31'd0, bus.ram_we},     32'd0);
    chk("raw.wr.rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    nxt();
    bus.cpu_req = 1'b0;
    bus.up_session = 1'b1;
    smp();
    chk("raw.rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
    chk("raw.rdata",  {24'd0, bus.cpu_rdata},  32'h11);
    chk_gnt("raw.idle", 1'b0, 1'b0, 1'b0);

    // All three at once: up, blt, cpu on successive cycles.
    nxt();
    bus.up_session = 1'b0;
    bus.up_req = 1'b1; bus.up_addr = 12'h0A0; bus.up_wdata = 8'h77;
    bus.blt_req = 1'b1; bus.blt_addr = 12'h010;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h0A0;
    smp();
    chk_gnt("all.c1", 1'b1, 1'b0, 1'b0);
    nxt();
    bus.up_req = 1'b0;
    smp();
    chk_gnt("all.c2", 1'b0, 1'b1, 1'b0);
    nxt();
    bus.blt_req = 1'b0;
    smp();
    chk_gnt("all.c3", 1'b0, 1'b0, 1'b1);
    chk("all.blt_rvalid", {31'd0, bus.blt_rvalid}, 32'd1);
    chk("all.blt_rdata",  {24'd0, bus.blt_rdata},  32'h3C);
    chk("all.cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    nxt();
    bus.cpu_req = 1'b0;
    smp();
    chk("all.cpu_rvalid2", {31'd0, bus.cpu_rvalid}, 32'd1);
    chk("all.cpu_rdata",   {24'd0, bus.cpu_rdata},  32'h77);
    chk_gnt("all.c4", 1'b0, 1'b0, 1'b0);

    // Starvation: blitter wins 8 cycles, CPU forced in on cycle 9.
    nxt();
    bus.blt_req = 1'b1; bus.blt_addr = 12'h010;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200;
    for (int c = 1; c <= 8; c++) begin
      smp();
      chk_gnt("starve.blt", 1'b0, 1'b1, 1'b0);
      if (c == 2) chk("starve.busy", {31'd0, bus.busy}, 32'd1);
      nxt();
    end
    smp();
    chk_gnt("starve.c9", 1'b0, 1'b0, 1'b1);
    chk("starve.sat", 32'(dut.starve_q), 32'd8);
    nxt();
    smp();
    chk_gnt("starve.c10", 1'b0, 1'b1, 1'b0);
    chk("starve.clr",    32'(dut.starve_q), 32'd0);
    chk("starve.rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
    chk("starve.rdata",  {24'd0, bus.cpu_rdata},  32'hA2);
    nxt();
    bus.blt_req = 1'b0; bus.cpu_req = 1'b0;
    smp();
    chk("starve.blt_rvalid", {31'd0, bus.blt_rvalid}, 32'd1);
    chk_gnt("starve.idle", 1'b0, 1'b0, 1'b0);
    nxt();
    smp();
    chk("idle.busy", {31'd0, bus.busy}, 32'd0);

    // Reset lands on a blitter read grant: the return is discarded.
    nxt();
    bus.blt_req = 1'b1; bus.blt_addr = 12'h010;
    smp();
    chk_gnt("rstmid.gnt", 1'b0, 1'b1, 1'b0);
    res = 1'b0;
    #1;
    chk_gnt("rstmid.gnt0", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    smp();
    chk_idle("rstmid.c1");
    @(posedge clk);
    smp();
    chk_idle("rstmid.c2");
    res = 1'b1;
    #1;
    chk_gnt("rstmid.first", 1'b0, 1'b1, 1'b0);
    nxt();
    bus.blt_req = 1'b0;
    smp();
    chk("rstmid.rvalid", {31'd0, bus.blt_rvalid}, 32'd1);
    chk("rstmid.rdata",  {24'd0, bus.blt_rdata},  32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
